// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg
//   Shared types for the data-memory arbiter. It holds the arbiter state
//   encoding, the owner enum used to pick a winner, and a helper that decides
//   whether a requester is presenting a transaction.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // A requester is active when it reads or writes any byte.
  function automatic logic req_valid(input logic rd, input logic [3:0] we);
    return rd | (|we);
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout
//   Counts the cycles a grant has waited for memory. The count is cleared
//   while clr is high and advances while en is high. expire is high while the
//   count equals TIMEOUT-1.
// Ports
//   clock  : clock, all state on posedge
//   reset  : asynchronous active-low reset
//   clr    : synchronous clear (takes priority over en)
//   en     : count enable
//   expire : count has reached TIMEOUT-1
module mem_arb_timeout #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one 32-bit data memory port between the CPU data controller (C)
//   and the DMA engine (D). One transaction is granted at a time. The grant is
//   held until memory answers or the timeout aborts the access. Read data and
//   the ready pulse go back to the owner only. DMA wins ties, but at most
//   DMA_BURST_MAX times in a row while C waits. After that, C wins the tie.
//
// Handshake: a requester raises read or a nonzero we and holds address and
//   data until its one-cycle ready pulse. It drops the request in the cycle
//   after ready. Memory answers with a one-cycle mem_ready pulse. mem_rdata is
//   valid only in that cycle. The mem_* strobes stay constant for the whole
//   grant.
//
// Ports
//   clock, reset                   : clock, asynchronous active-low reset
//   c_read/c_we/c_addr/c_wdata     : requester C command (we wins over read)
//   c_rdata/c_ready/c_err          : requester C return (err = timeout abort)
//   d_*                            : same set for requester D
//   mem_read/mem_we/mem_addr/wdata : registered command to memory
//   mem_rdata/mem_ready            : memory return
//   dbg_state/dbg_streak           : arbiter state and DMA streak, for observation
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DMA_BURST_MAX = 4,
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_W     = 8,
  localparam int STREAK_W     = $clog2(DMA_BURST_MAX + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                c_read,
  input  logic [3:0]          c_we,
  input  logic [31:0]         c_addr,
  input  logic [31:0]         c_wdata,
  output logic [31:0]         c_rdata,
  output logic                c_ready,
  output logic                c_err,
  input  logic                d_read,
  input  logic [3:0]          d_we,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_wdata,
  output logic [31:0]         d_rdata,
  output logic                d_ready,
  output logic                d_err,
  output logic                mem_read,
  output logic [3:0]          mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready,
  output arb_state_t          dbg_state,
  output logic [STREAK_W-1:0] dbg_streak
);

  arb_state_t          state, state_next;
  owner_t              winner;
  logic                win_valid;
  logic                c_valid, d_valid;
  logic                in_grant, grant_entry, done, expire;
  logic [STREAK_W-1:0] streak;

  assign c_valid     = req_valid(c_read, c_we);
  assign d_valid     = req_valid(d_read, d_we);
  assign in_grant    = (state == GNT_C) || (state == GNT_D);
  assign done        = in_grant && (mem_ready || expire);
  assign grant_entry = (state == IDLE) && win_valid;

  // Arbitration. D wins ties until it has won DMA_BURST_MAX ties in a row.
  always_comb begin
    win_valid = 1'b0;
    winner    = OWN_C;
    if (c_valid && d_valid) begin
      win_valid = 1'b1;
      winner    = (streak == STREAK_W'(DMA_BURST_MAX)) ? OWN_C : OWN_D;
    end else if (c_valid) begin
      win_valid = 1'b1;
      winner    = OWN_C;
    end else if (d_valid) begin
      win_valid = 1'b1;
      winner    = OWN_D;
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (win_valid) state_next = (winner == OWN_C) ? GNT_C : GNT_D;
      GNT_C, GNT_D: if (done) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // FSM: outputs. Only the owner sees ready, err or data.
  // rdata is nonzero only in a real mem_ready cycle.
  always_comb begin
    c_ready = 1'b0;
    c_err   = 1'b0;
    c_rdata = '0;
    d_ready = 1'b0;
    d_err   = 1'b0;
    d_rdata = '0;
    if (state == GNT_C) begin
      c_ready = done;
      c_err   = expire && !mem_ready;
      c_rdata = mem_ready ? mem_rdata : '0;
    end else if (state == GNT_D) begin
      d_ready = done;
      d_err   = expire && !mem_ready;
      d_rdata = mem_ready ? mem_rdata : '0;
    end
  end

  // Command capture. When a requester both reads and writes, it is treated
  // as a write, so mem_read is suppressed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_read  <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_entry) begin
      if (winner == OWN_C) begin
        mem_read  <= c_read && (c_we == 4'b0000);
        mem_we    <= c_we;
        mem_addr  <= c_addr;
        mem_wdata <= c_wdata;
      end else begin
        mem_read  <= d_read && (d_we == 4'b0000);
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
    end else if (done) begin
      mem_read  <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  // DMA streak. It counts D wins that happen while C is waiting. A C grant
  // clears it. A D grant with C idle leaves it unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (grant_entry) begin
      if (winner == OWN_C) begin
        streak <= '0;
      end else if (c_valid && (streak != STREAK_W'(DMA_BURST_MAX))) begin
        streak <= streak + 1'b1;
      end
    end
  end

  // The timer is held clear outside a grant, so it starts at 0 on grant entry.
  mem_arb_timeout #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clr    (!in_grant),
    .en     (in_grant && !mem_ready),
    .expire (expire)
  );

  assign dbg_state  = state;
  assign dbg_streak = streak;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed bench for data_mem_arbiter. It uses DMA_BURST_MAX=4 and
//   TIMEOUT=8. Inputs change 1 time unit after the rising edge. Outputs are
//   checked on the falling edge.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        c_read = 1'b0, d_read = 1'b0;
  logic [3:0]  c_we = '0, d_we = '0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] c_rdata, d_rdata;
  logic        c_ready, c_err, d_ready, d_err;
  logic        mem_read;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  arb_state_t  dbg_state;
  logic [2:0]  dbg_streak;
  logic [136:0] all_outs;

  int vectors = 0;
  int miscompares = 0;

  data_mem_arbiter #(
    .DMA_BURST_MAX (4),
    .TIMEOUT       (8),
    .TIMEOUT_W     (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .c_read     (c_read),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_rdata    (c_rdata),
    .c_ready    (c_ready),
    .c_err      (c_err),
    .d_read     (d_read),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .d_err      (d_err),
    .mem_read   (mem_read),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dbg_state  (dbg_state),
    .dbg_streak (dbg_streak)
  );

  assign all_outs = {mem_read, mem_we, mem_addr, mem_wdata, c_ready, c_err, c_rdata,
                     d_ready, d_err, d_rdata};

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    tick();
    reset  = 1'b1;
    d_read = 1'b1;
    d_addr = 32'h0000_0100;
    tick();
    @(negedge clock);
    vectors++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL pre_reset_gnt_d: got %h expected %h", {mem_read, mem_addr}, {1'b1, 32'h0000_0100});
    end
    vectors++;
    if (dbg_state !== GNT_D) begin
      miscompares++;
      $display("FAIL pre_reset_state: got %0d expected %0d", dbg_state, GNT_D);
    end
    // Assert reset between edges. Memory never answered.
    @(negedge clock);
    #1;
    reset  = 1'b0;
    d_read = 1'b0;
    #1;
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outs: got %h expected 0", all_outs);
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL async_reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    tick();
    reset  = 1'b1;
    c_read = 1'b1;
    c_addr = 32'h0000_0044;
    tick();
    @(negedge clock);
    vectors++;
    if ({dbg_state, mem_read, mem_addr} !== {GNT_C, 1'b1, 32'h0000_0044}) begin
      miscompares++;
      $display("FAIL post_reset_gnt: got %h expected %h", {dbg_state, mem_read, mem_addr},
               {GNT_C, 1'b1, 32'h0000_0044});
    end
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    @(negedge clock);
    vectors++;
    if ({c_ready, c_rdata} !== {1'b1, 32'hCAFE_0001}) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %h expected %h", {c_ready, c_rdata}, {1'b1, 32'hCAFE_0001});
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    c_read    = 1'b0;
  endtask

  task automatic test_c_read();
    c_read = 1'b1;
    c_addr = 32'h8000_0010;
    tick();  // grant entry: strobe in cycle n+1
    @(negedge clock);
    vectors++;
    if ({mem_read, mem_we, mem_addr} !== {1'b1, 4'b0000, 32'h8000_0010}) begin
      miscompares++;
      $display("FAIL c_read_strobe: got %h expected %h", {mem_read, mem_we, mem_addr},
               {1'b1, 4'b0000, 32'h8000_0010});
    end
    tick();
    tick();
    @(negedge clock);
    vectors++;
    if ({c_ready, d_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL c_read_wait: got %b expected 00", {c_ready, d_ready});
    end
    tick();  // 3 cycles after strobe
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clock);
    vectors++;
    if ({c_ready, c_err, c_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL c_read_ready: got %h expected %h", {c_ready, c_err, c_rdata},
               {1'b1, 1'b0, 32'h1234_5678});
    end
    vectors++;
    if ({d_ready, d_err, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL c_read_d_quiet: got %h expected 0", {d_ready, d_err, d_rdata});
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    c_read    = 1'b0;
    @(negedge clock);
    vectors++;
    if ({dbg_state, mem_read, mem_addr} !== {IDLE, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL c_read_idle: got %h expected 0", {dbg_state, mem_read, mem_addr});
    end
  endtask

  task automatic test_arbitration();
    bit       exp_is_d[10]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int       exp_streak[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    logic [31:0] exp_addr;
    c_read = 1'b1;
    c_addr = 32'h0000_00C0;
    d_read = 1'b1;
    d_addr = 32'h0000_00D0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clock);
      exp_addr = exp_is_d[i] ? 32'h0000_00D0 : 32'h0000_00C0;
      vectors++;
      if ({dbg_state, mem_addr} !== {(exp_is_d[i] ? GNT_D : GNT_C), exp_addr}) begin
        miscompares++;
        $display("FAIL arb_grant_%0d: got %h expected %h", i, {dbg_state, mem_addr},
                 {(exp_is_d[i] ? GNT_D : GNT_C), exp_addr});
      end
      vectors++;
      if (dbg_streak !== 3'(exp_streak[i])) begin
        miscompares++;
        $display("FAIL arb_streak_%0d: got %0d expected %0d", i, dbg_streak, exp_streak[i]);
      end
      tick();
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_0A00 + 32'(i);
      @(negedge clock);
      vectors++;
      if ({c_ready, d_ready} !== (exp_is_d[i] ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL arb_ready_%0d: got %b expected %b", i, {c_ready, d_ready},
                 (exp_is_d[i] ? 2'b01 : 2'b10));
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
    c_read = 1'b0;
    d_read = 1'b0;
  endtask

  task automatic test_write_priority();
    c_read  = 1'b1;
    c_we    = 4'b0011;
    c_addr  = 32'h0000_0020;
    c_wdata = 32'hAABB_CCDD;
    tick();
    @(negedge clock);
    vectors++;
    if ({mem_read, mem_we, mem_addr, mem_wdata} !== {1'b0, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD}) begin
      miscompares++;
      $display("FAIL write_cmd: got %h expected %h", {mem_read, mem_we, mem_addr, mem_wdata},
               {1'b0, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD});
    end
    tick();
    mem_ready = 1'b1;
    @(negedge clock);
    vectors++;
    if ({c_ready, c_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL write_ready: got %b expected 10", {c_ready, c_err});
    end
    tick();
    mem_ready = 1'b0;
    c_read    = 1'b0;
    c_we      = '0;
    c_wdata   = '0;
  endtask

  task automatic test_timeout();
    d_read    = 1'b1;
    d_addr    = 32'h0000_0300;
    mem_rdata = 32'hFFFF_FFFF;  // must not leak through on an abort
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      @(negedge clock);
      if (k < 8) begin
        vectors++;
        if ({d_ready, d_err} !== 2'b00) begin
          miscompares++;
          $display("FAIL timeout_wait_%0d: got %b expected 00", k, {d_ready, d_err});
        end
      end else begin
        vectors++;
        if ({d_ready, d_err, d_rdata} !== {2'b11, 32'h0}) begin
          miscompares++;
          $display("FAIL timeout_abort: got %h expected %h", {d_ready, d_err, d_rdata}, {2'b11, 32'h0});
        end
      end
    end
    tick();
    d_read    = 1'b0;
    mem_rdata = '0;
    @(negedge clock);
    vectors++;
    if ({dbg_state, mem_read} !== {IDLE, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_idle: got %h expected 0", {dbg_state, mem_read});
    end
  endtask

  task automatic test_timeout_race();
    c_read = 1'b1;
    c_addr = 32'h0000_0500;
    tick();          // GNT cycle 1
    repeat (7) tick();  // GNT cycle 8: timeout expires here
    mem_ready = 1'b1;
    mem_rdata = 32'h5A5A_A5A5;
    @(negedge clock);
    vectors++;
    if ({c_ready, c_err, c_rdata} !== {2'b10, 32'h5A5A_A5A5}) begin
      miscompares++;
      $display("FAIL timeout_race: got %h expected %h", {c_ready, c_err, c_rdata}, {2'b10, 32'h5A5A_A5A5});
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    c_read    = 1'b0;
  endtask

  task automatic test_idle_ready();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    vectors++;
    if ({c_ready, c_err, c_rdata, d_ready, d_err, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL idle_ready: got %h expected 0", {c_ready, c_err, c_rdata, d_ready, d_err, d_rdata});
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clock);
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL idle_stays: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_c_read();
    tick();
    test_arbitration();
    tick();
    test_write_priority();
    tick();
    test_timeout();
    tick();
    test_timeout_race();
    tick();
    test_idle_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
